dmem_access_unit: RTL and testbench

Data-memory access controller for the MEM stage of the five-stage pipeline. It takes the load/store control and data held in the EXE/MEM pipeline register, runs a request/acknowledge transaction on the data-memory bus, and returns aligned, extended load data toward MEM/WB. It drives `MEM_Stall` back to the pipeline registers until the access completes, and flags misaligned accesses instead of issuing them. Byte order is little-endian.

---
 rtl/dmem_access_unit.sv | 140 ++++++++++++++
 tb/tb_dmem_access_unit.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_access_unit.sv
// MEM-stage data-memory controller: IDLE->WAIT->DONE req/ack transaction, 3+ cycles per aligned op.
// Stalls the pipeline until Ack; misaligned ops are flagged in one cycle with no bus activity.
module dmem_access_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        MEM_MemRead,
    input  logic        MEM_MemWrite,
    input  logic        MEM_MemByte,
    input  logic        MEM_MemHalf,
    input  logic        MEM_MemSignExt,
    input  logic [31:0] MEM_ALU_Result,
    input  logic [31:0] MEM_ReadData2,
    input  logic        WB_Stall,
    output logic [31:0] MEM_ReadData,
    output logic        MEM_Stall,
    output logic        MEM_AddrErrLoad,
    output logic        MEM_AddrErrStore,
    output logic        DMEM_Req,
    output logic        DMEM_WE,
    output logic [31:0] DMEM_Addr,
    output logic [3:0]  DMEM_BE,
    output logic [31:0] DMEM_WData,
    input  logic        DMEM_Ack,
    input  logic [31:0] DMEM_RData
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t      state, stateNext;
    logic        memOp, isWord, misalign, issue;
    logic [3:0]  beNext;
    logic [31:0] wdataNext;
    logic [1:0]  laneQ;
    logic        byteQ, halfQ, signExtQ, loadQ;
    logic [7:0]  lane8;
    logic [15:0] half16;
    logic [31:0] loadFmt;

    // Byte takes priority over half if both are ever set.
    always_comb begin
        memOp    = MEM_MemRead | MEM_MemWrite;
        isWord   = !MEM_MemByte && !MEM_MemHalf;
        misalign = (!MEM_MemByte && MEM_MemHalf && MEM_ALU_Result[0]) ||
                   (isWord && (MEM_ALU_Result[1:0] != 2'b00));
        issue    = (state == IDLE) && memOp && !misalign;
    end

    always_comb begin
        beNext    = 4'b1111;
        wdataNext = MEM_ReadData2;
        if (MEM_MemByte) begin
            beNext    = 4'b0001 << MEM_ALU_Result[1:0];
            wdataNext = {4{MEM_ReadData2[7:0]}};
        end else if (MEM_MemHalf) begin
            beNext    = MEM_ALU_Result[1] ? 4'b1100 : 4'b0011;
            wdataNext = {2{MEM_ReadData2[15:0]}};
        end
    end

    // Load formatting uses the lane/size captured at issue, not the live pipeline inputs.
    always_comb begin
        lane8   = DMEM_RData[{laneQ, 3'b000} +: 8];
        half16  = laneQ[1] ? DMEM_RData[31:16] : DMEM_RData[15:0];
        loadFmt = DMEM_RData;
        if (byteQ)
            loadFmt = {{24{signExtQ & lane8[7]}}, lane8};
        else if (halfQ)
            loadFmt = {{16{signExtQ & half16[15]}}, half16};
    end

    always_comb begin
        stateNext        = state;
        MEM_Stall        = 1'b0;
        MEM_AddrErrLoad  = 1'b0;
        MEM_AddrErrStore = 1'b0;
        case (state)
            IDLE: begin
                if (memOp) begin
                    if (misalign) begin
                        MEM_AddrErrLoad  = MEM_MemRead;
                        MEM_AddrErrStore = MEM_MemWrite;
                    end else begin
                        MEM_Stall = 1'b1;
                        stateNext = WAIT;
                    end
                end
            end
            WAIT: begin
                MEM_Stall = 1'b1;
                if (DMEM_Ack)
                    stateNext = DONE;
            end
            DONE: begin
                if (!WB_Stall)
                    stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= stateNext;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            DMEM_Req     <= 1'b0;
            DMEM_WE      <= 1'b0;
            DMEM_Addr    <= 32'h0;
            DMEM_BE      <= 4'h0;
            DMEM_WData   <= 32'h0;
            MEM_ReadData <= 32'h0;
            laneQ        <= 2'b00;
            byteQ        <= 1'b0;
            halfQ        <= 1'b0;
            signExtQ     <= 1'b0;
            loadQ        <= 1'b0;
        end else if (issue) begin
            DMEM_Req   <= 1'b1;
            DMEM_WE    <= MEM_MemWrite;
            DMEM_Addr  <= {MEM_ALU_Result[31:2], 2'b00};
            DMEM_BE    <= beNext;
            DMEM_WData <= wdataNext;
            laneQ      <= MEM_ALU_Result[1:0];
            byteQ      <= MEM_MemByte;
            halfQ      <= MEM_MemHalf & ~MEM_MemByte;
            signExtQ   <= MEM_MemSignExt;
            loadQ      <= MEM_MemRead;
        end else if (state == WAIT && DMEM_Ack) begin
            DMEM_Req <= 1'b0;
            DMEM_WE  <= 1'b0;
            if (loadQ)
                MEM_ReadData <= loadFmt;
        end
    end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed bench for dmem_access_unit: drive at posedge+1, sample at posedge+2.
module tb_dmem_access_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        memRead = 1'b0, memWrite = 1'b0, memByte = 1'b0, memHalf = 1'b0, memSignExt = 1'b0;
    logic [31:0] aluResult = 32'h0, readData2 = 32'h0;
    logic        wbStall = 1'b0;
    logic [31:0] memReadData;
    logic        memStall, addrErrLoad, addrErrStore;
    logic        dmemReq, dmemWe;
    logic [31:0] dmemAddr, dmemWData;
    logic [3:0]  dmemBe;
    logic        dmemAck = 1'b0;
    logic [31:0] dmemRData = 32'h0;

    int errors = 0;
    int checks = 0;

    dmem_access_unit dut (
        .clk(clk), .rst(rst),
        .MEM_MemRead(memRead), .MEM_MemWrite(memWrite), .MEM_MemByte(memByte),
        .MEM_MemHalf(memHalf), .MEM_MemSignExt(memSignExt),
        .MEM_ALU_Result(aluResult), .MEM_ReadData2(readData2), .WB_Stall(wbStall),
        .MEM_ReadData(memReadData), .MEM_Stall(memStall),
        .MEM_AddrErrLoad(addrErrLoad), .MEM_AddrErrStore(addrErrStore),
        .DMEM_Req(dmemReq), .DMEM_WE(dmemWe), .DMEM_Addr(dmemAddr), .DMEM_BE(dmemBe),
        .DMEM_WData(dmemWData), .DMEM_Ack(dmemAck), .DMEM_RData(dmemRData)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rd, input logic wr, input logic by, input logic hf,
                         input logic sx, input logic [31:0] addr, input logic [31:0] wd);
        memRead = rd; memWrite = wr; memByte = by; memHalf = hf; memSignExt = sx;
        aluResult = addr; readData2 = wd;
    endtask

    task automatic clearOp();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        checks++; if (dmemReq !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", dmemReq); end
        checks++; if (dmemWe !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", dmemWe); end
        checks++; if (dmemAddr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", dmemAddr); end
        checks++; if (dmemBe !== 4'h0) begin errors++; $display("FAIL reset_be: got %b want 0", dmemBe); end
        checks++; if (memReadData !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", memReadData); end
        checks++; if (memStall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", memStall); end
        checks++; if ({addrErrLoad, addrErrStore} !== 2'b00) begin errors++; $display("FAIL reset_err: got %b want 00", {addrErrLoad, addrErrStore}); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_word_load();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h100, 32'h0);
        #1;
        checks++; if (memStall !== 1'b1) begin errors++; $display("FAIL wl_stall_c0: got %b want 1", memStall); end
        checks++; if (dmemReq !== 1'b0) begin errors++; $display("FAIL wl_req_c0: got %b want 0", dmemReq); end
        tick();
        checks++; if (dmemReq !== 1'b1) begin errors++; $display("FAIL wl_req_c1: got %b want 1", dmemReq); end
        checks++; if (memStall !== 1'b1) begin errors++; $display("FAIL wl_stall_c1: got %b want 1", memStall); end
        checks++; if (dmemAddr !== 32'h100) begin errors++; $display("FAIL wl_addr: got %h want 00000100", dmemAddr); end
        checks++; if (dmemBe !== 4'b1111) begin errors++; $display("FAIL wl_be: got %b want 1111", dmemBe); end
        checks++; if (dmemWe !== 1'b0) begin errors++; $display("FAIL wl_we: got %b want 0", dmemWe); end
        tick();
        checks++; if (dmemReq !== 1'b1) begin errors++; $display("FAIL wl_req_c2: got %b want 1", dmemReq); end
        checks++; if (memStall !== 1'b1) begin errors++; $display("FAIL wl_stall_c2: got %b want 1", memStall); end
        dmemAck = 1'b1; dmemRData = 32'hDEADBEEF;
        tick();
        dmemAck = 1'b0; dmemRData = 32'h0;
        clearOp();
        #1;
        checks++; if (dmemReq !== 1'b0) begin errors++; $display("FAIL wl_req_c3: got %b want 0", dmemReq); end
        checks++; if (memStall !== 1'b0) begin errors++; $display("FAIL wl_stall_c3: got %b want 0", memStall); end
        checks++; if (memReadData !== 32'hDEADBEEF) begin errors++; $display("FAIL wl_rdata: got %h want deadbeef", memReadData); end
        tick();
    endtask

    task automatic test_byte_load();
        logic [31:0] want [2];
        want[0] = 32'hFFFFFF80;
        want[1] = 32'h00000080;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b0, 1'b1, 1'b0, (i == 0), 32'h103, 32'h0);
            #1;
            checks++; if (addrErrLoad !== 1'b0) begin errors++; $display("FAIL bl_err[%0d]: got %b want 0", i, addrErrLoad); end
            tick();
            checks++; if (dmemBe !== 4'b1000) begin errors++; $display("FAIL bl_be[%0d]: got %b want 1000", i, dmemBe); end
            checks++; if (dmemAddr !== 32'h100) begin errors++; $display("FAIL bl_addr[%0d]: got %h want 00000100", i, dmemAddr); end
            dmemAck = 1'b1; dmemRData = 32'h80FF0011;
            tick();
            dmemAck = 1'b0;
            clearOp();
            #1;
            checks++; if (memReadData !== want[i]) begin errors++; $display("FAIL bl_rdata[%0d]: got %h want %h", i, memReadData, want[i]); end
            tick();
        end
    endtask

    task automatic test_half_store();
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h202, 32'h1234ABCD);
        tick();
        checks++; if (dmemWe !== 1'b1) begin errors++; $display("FAIL hs_we: got %b want 1", dmemWe); end
        checks++; if (dmemBe !== 4'b1100) begin errors++; $display("FAIL hs_be: got %b want 1100", dmemBe); end
        checks++; if (dmemWData !== 32'hABCDABCD) begin errors++; $display("FAIL hs_wdata: got %h want abcdabcd", dmemWData); end
        checks++; if (dmemAddr !== 32'h200) begin errors++; $display("FAIL hs_addr: got %h want 00000200", dmemAddr); end
        dmemAck = 1'b1; dmemRData = 32'hFFFFFFFF;
        tick();
        dmemAck = 1'b0;
        clearOp();
        #1;
        checks++; if ({dmemReq, dmemWe} !== 2'b00) begin errors++; $display("FAIL hs_done_bus: got %b want 00", {dmemReq, dmemWe}); end
        checks++; if (memReadData !== 32'h00000080) begin errors++; $display("FAIL hs_rdata_hold: got %h want 00000080", memReadData); end
        tick();
    endtask

    task automatic test_misaligned();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h101, 32'h0);
        #1;
        checks++; if (addrErrLoad !== 1'b1) begin errors++; $display("FAIL ma_errload: got %b want 1", addrErrLoad); end
        checks++; if (addrErrStore !== 1'b0) begin errors++; $display("FAIL ma_errstore0: got %b want 0", addrErrStore); end
        checks++; if (memStall !== 1'b0) begin errors++; $display("FAIL ma_stall: got %b want 0", memStall); end
        tick();
        checks++; if (dmemReq !== 1'b0) begin errors++; $display("FAIL ma_req: got %b want 0", dmemReq); end
        checks++; if (addrErrLoad !== 1'b1) begin errors++; $display("FAIL ma_errload_hold: got %b want 1", addrErrLoad); end
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h201, 32'h0);
        #1;
        checks++; if ({addrErrLoad, addrErrStore} !== 2'b01) begin errors++; $display("FAIL ma_half_store: got %b want 01", {addrErrLoad, addrErrStore}); end
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h102, 32'h0);
        #1;
        checks++; if ({addrErrLoad, memStall} !== 2'b01) begin errors++; $display("FAIL ma_half_aligned: got %b want 01", {addrErrLoad, memStall}); end
        clearOp();
        tick();
        checks++; if (dmemReq !== 1'b0) begin errors++; $display("FAIL ma_req_after: got %b want 0", dmemReq); end
    endtask

    task automatic test_wb_stall();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h300, 32'h55);
        tick();
        dmemAck = 1'b1;
        tick();
        dmemAck = 1'b0;
        wbStall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if ({memStall, dmemReq} !== 2'b00) begin errors++; $display("FAIL wb_hold[%0d]: got %b want 00", i, {memStall, dmemReq}); end
            tick();
        end
        wbStall = 1'b0;
        clearOp();
        #1;
        checks++; if ({memStall, dmemReq} !== 2'b00) begin errors++; $display("FAIL wb_release: got %b want 00", {memStall, dmemReq}); end
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h304, 32'h0);
        #1;
        checks++; if (memStall !== 1'b1) begin errors++; $display("FAIL wb_idle_again: got %b want 1", memStall); end
        tick();
        dmemAck = 1'b1; dmemRData = 32'h80000000;
        tick();
        dmemAck = 1'b0;
        clearOp();
        #1;
        checks++; if (memReadData !== 32'h80000000) begin errors++; $display("FAIL wb_word_sext: got %h want 80000000", memReadData); end
        tick();
    endtask

    task automatic test_reset_in_wait();
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h106, 32'h0);
        tick();
        checks++; if (dmemReq !== 1'b1) begin errors++; $display("FAIL rw_req_before: got %b want 1", dmemReq); end
        #1;
        rst = 1'b0;
        clearOp();
        #1;
        checks++; if (dmemReq !== 1'b0) begin errors++; $display("FAIL rw_req_async: got %b want 0", dmemReq); end
        checks++; if ({dmemAddr, dmemBe} !== 36'h0) begin errors++; $display("FAIL rw_bus: got %h want 0", {dmemAddr, dmemBe}); end
        checks++; if (memReadData !== 32'h0) begin errors++; $display("FAIL rw_rdata: got %h want 0", memReadData); end
        checks++; if (memStall !== 1'b0) begin errors++; $display("FAIL rw_stall: got %b want 0", memStall); end
        tick();
        rst = 1'b1;
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h106, 32'h0);
        #1;
        checks++; if (memStall !== 1'b1) begin errors++; $display("FAIL rw_new_stall: got %b want 1", memStall); end
        tick();
        checks++; if (dmemBe !== 4'b1100) begin errors++; $display("FAIL rw_new_be: got %b want 1100", dmemBe); end
        dmemAck = 1'b1; dmemRData = 32'h80011234;
        tick();
        dmemAck = 1'b0;
        clearOp();
        #1;
        checks++; if (memReadData !== 32'hFFFF8001) begin errors++; $display("FAIL rw_new_rdata: got %h want ffff8001", memReadData); end
        tick();
    endtask

    initial begin
        test_reset();
        test_word_load();
        test_byte_load();
        test_half_store();
        test_misaligned();
        test_wb_stall();
        test_reset_in_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
